// File: rtl/ext_r_gen.sv
// ext_r_gen: AXI read-data (R) channel transmitter.
// Accepts one burst command at a time. It turns a raw data-word stream into a
// tagged R burst (ID/USER/RESP, LAST on the final beat). Error bursts emit
// SLVERR beats with zero data and do not consume source words.
// The R outputs come straight from a single output register that obeys the
// AXI hold rule.

module ext_r_gen #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // Burst command
    input  logic                  cmd_valid_i,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [USER_WIDTH-1:0] cmd_user_i,
    input  logic                  cmd_err_i,
    output logic                  cmd_ready_o,

    // Raw source data
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  data_ready_o,

    // R channel
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  r_last_o,
    input  logic                  r_ready_i,

    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Burst control state
    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    // Output register
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [USER_WIDTH-1:0] r_user_q, r_user_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic                  r_last_q, r_last_d;

    // Decoded handshakes
    logic out_free;
    logic beat_avail;
    logic load;
    logic last_beat;
    logic cmd_fire;

    // Handshake decode: when the output register can take a beat, and whether one exists
    always_comb begin
        out_free     = !r_valid_q || r_ready_i;
        cmd_ready_o  = (state_q == ST_IDLE) && !rst_i;
        data_ready_o = (state_q == ST_STREAM) && out_free && !rst_i;
        cmd_fire     = cmd_valid_i && cmd_ready_o;
        // Error bursts synthesise a beat on every load opportunity
        beat_avail   = ((state_q == ST_STREAM) && data_valid_i) || (state_q == ST_ERR);
        load         = out_free && beat_avail && !rst_i;
        last_beat    = (cnt_q == len_q);
    end

    // Burst FSM: latch the command on accept, count loaded beats, return to idle on LAST
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        id_d    = id_q;
        user_d  = user_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = cmd_err_i ? ST_ERR : ST_STREAM;
                    cnt_d   = '0;
                    len_d   = cmd_len_i;
                    id_d    = cmd_id_i;
                    user_d  = cmd_user_i;
                end
            end
            ST_STREAM, ST_ERR: begin
                if (load) begin
                    // Wrap is harmless: the LAST beat always leaves the state
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load a new beat, or drop valid once the current one is taken
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_user_d  = r_user_q;
        r_id_d    = r_id_q;
        r_last_d  = r_last_q;
        if (load) begin
            r_valid_d = 1'b1;
            r_data_d  = (state_q == ST_STREAM) ? data_i : '0;
            r_resp_d  = (state_q == ST_ERR) ? RESP_SLVERR : RESP_OKAY;
            r_user_d  = user_q;
            r_id_d    = id_q;
            r_last_d  = last_beat;
        end else if (r_ready_i) begin
            r_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            id_q      <= '0;
            user_q    <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_user_q  <= '0;
            r_id_q    <= '0;
            r_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            id_q      <= id_d;
            user_q    <= user_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_user_q  <= r_user_d;
            r_id_q    <= r_id_d;
            r_last_q  <= r_last_d;
        end
    end

    // Output drive
    always_comb begin
        r_valid_o = r_valid_q;
        r_data_o  = r_data_q;
        r_resp_o  = r_resp_q;
        r_user_o  = r_user_q;
        r_id_o    = r_id_q;
        r_last_o  = r_last_q;
        busy_o    = (state_q != ST_IDLE) || r_valid_q;
    end

endmodule

// File: tb/tb_ext_r_gen.sv
// Testbench for ext_r_gen: randomized commands, data and backpressure, checked
// against a burst-level reference model of expected R beats.

module tb_ext_r_gen;

    localparam int IW = 4;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid;
    logic [IW-1:0] cmd_id;
    logic [LW-1:0] cmd_len;
    logic [UW-1:0] cmd_user;
    logic          cmd_err;
    logic          cmd_ready;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          data_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic [UW-1:0] r_user;
    logic [IW-1:0] r_id;
    logic          r_last;
    logic          r_ready;
    logic          busy;

    ext_r_gen #(
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_id_i     (cmd_id),
        .cmd_len_i    (cmd_len),
        .cmd_user_i   (cmd_user),
        .cmd_err_i    (cmd_err),
        .cmd_ready_o  (cmd_ready),
        .data_valid_i (data_valid),
        .data_i       (data),
        .data_ready_o (data_ready),
        .r_valid_o    (r_valid),
        .r_data_o     (r_data),
        .r_resp_o     (r_resp),
        .r_user_o     (r_user),
        .r_id_o       (r_id),
        .r_last_o     (r_last),
        .r_ready_i    (r_ready),
        .busy_o       (busy)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [LW-1:0] len;
        logic [UW-1:0] user;
        logic          err;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    cmd_t          cmd_q[$];
    logic [DW-1:0] data_q[$];
    beat_t         exp_q[$];
    int            beat_cyc[$];
    int            cmd_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs
    int ready_pct = 100;
    int data_pct  = 100;
    int cmd_pct   = 100;
    bit toggle    = 1'b0;
    bit mon_en    = 1'b0;
    logic [DW-1:0] seq_base = '0;

    // Monitor state
    int  cyc       = 0;
    int  n_beats   = 0;
    int  allowed   = 0;
    int  consumed  = 0;
    bit  cmd_fire  = 1'b0;
    bit  data_fire = 1'b0;
    bit  hold_chk  = 1'b0;
    logic [127:0] held;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue a command plus the beats it must produce (and the source words it needs)
    task automatic add_cmd(input int id, input int len, input int user, input bit err,
                           input bit seq);
        cmd_t  c;
        beat_t b;
        logic [DW-1:0] w;
        c.id   = IW'(id);
        c.len  = LW'(len);
        c.user = UW'(user);
        c.err  = err;
        cmd_q.push_back(c);
        for (int k = 0; k <= len; k++) begin
            if (err) begin
                w = '0;
            end else begin
                if (seq) begin
                    w = seq_base;
                    seq_base = seq_base + 1;
                end else begin
                    w = {$urandom, $urandom};
                end
                data_q.push_back(w);
            end
            b.data = w;
            b.resp = err ? 2'b10 : 2'b00;
            b.user = c.user;
            b.id   = c.id;
            b.last = (k == len);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0) && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    function automatic int bcyc(input int i);
        return (beat_cyc.size() > i) ? beat_cyc[i] : -1000;
    endfunction

    task automatic clear_trace();
        beat_cyc.delete();
        cmd_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r_valid"}, r_valid, 0);
        check({tag, "_r_fields"}, {r_data, r_resp, r_user, r_id, r_last}, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Command driver
    initial begin
        cmd_valid = 1'b0;
        cmd_id = '0;
        cmd_len = '0;
        cmd_user = '0;
        cmd_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_fire) begin
                void'(cmd_q.pop_front());
                cmd_valid = 1'b0;
            end
            if (cmd_q.size() > 0) begin
                cmd_valid = cmd_valid || ($urandom_range(0, 99) < cmd_pct);
                cmd_id    = cmd_q[0].id;
                cmd_len   = cmd_q[0].len;
                cmd_user  = cmd_q[0].user;
                cmd_err   = cmd_q[0].err;
            end else begin
                cmd_valid = 1'b0;
            end
        end
    end

    // Source data driver
    initial begin
        data_valid = 1'b0;
        data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (data_fire && data_q.size() > 0) begin
                void'(data_q.pop_front());
                data_valid = 1'b0;
            end
            if (data_q.size() > 0) begin
                data_valid = data_valid || ($urandom_range(0, 99) < data_pct);
                data       = data_q[0];
            end else begin
                data_valid = 1'b0;
                data       = '0;
            end
        end
    end

    // Downstream ready driver
    initial begin
        r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle) r_ready = ~r_ready;
            else        r_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor on the falling edge: handshakes, beat scoreboard, hold rule
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            cmd_fire  = cmd_valid && cmd_ready;
            data_fire = data_valid && data_ready;
            if (cmd_fire) begin
                cmd_cyc.push_back(cyc);
                if (!cmd_err) allowed += int'(cmd_len) + 1;
            end
            if (mon_en) begin
                if (data_fire) begin
                    consumed++;
                    check("data_overconsume", consumed <= allowed, 1);
                end
                if (hold_chk) begin
                    check("hold_valid", r_valid, 1);
                    check("hold_fields", {r_data, r_resp, r_user, r_id, r_last}, held);
                end
                if (r_valid && !r_ready) begin
                    check("dready_stall", data_ready, 0);
                end
                if (r_valid && r_ready) begin
                    n_beats++;
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("beat_extra", r_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", r_data, e.data);
                        check("beat_resp", r_resp, e.resp);
                        check("beat_id", r_id, e.id);
                        check("beat_user", r_user, e.user);
                        check("beat_last", r_last, e.last);
                    end
                end
                hold_chk = r_valid && !r_ready;
                held     = {r_data, r_resp, r_user, r_id, r_last};
            end else begin
                hold_chk = 1'b0;
            end
        end
    end

    initial begin
        int n0;
        int i;
        rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst0");
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst0_cmd_ready_after", cmd_ready, 1);

        // Single beat and first-beat latency
        clear_trace();
        seq_base = 64'hA5;
        add_cmd(3, 0, 5, 1'b0, 1'b1);
        wait_drain(100);
        check("t2_latency", bcyc(0) - ((cmd_cyc.size() > 0) ? cmd_cyc[0] : 0), 2);
        check("t2_nbeats", beat_cyc.size(), 1);

        // Eight back-to-back beats
        clear_trace();
        seq_base = 64'd1;
        add_cmd(1, 7, 2, 1'b0, 1'b1);
        wait_drain(200);
        check("t3_nbeats", beat_cyc.size(), 8);
        check("t3_span", bcyc(7) - bcyc(0), 7);

        // Backpressure with r_ready toggling
        toggle = 1'b1;
        add_cmd(6, 3, 1, 1'b0, 1'b0);
        wait_drain(200);
        toggle = 1'b0;

        // Error burst followed by a data burst whose words are already offered
        add_cmd(9, 2, 7, 1'b1, 1'b0);
        add_cmd(4, 1, 3, 1'b0, 1'b0);
        wait_drain(200);

        // Two queued commands: one bubble between bursts
        clear_trace();
        add_cmd(1, 1, 10, 1'b0, 1'b0);
        add_cmd(2, 1, 11, 1'b0, 1'b0);
        wait_drain(200);
        check("t6_gap0", bcyc(1) - bcyc(0), 1);
        check("t6_gap1", bcyc(2) - bcyc(1), 2);
        check("t6_gap2", bcyc(3) - bcyc(2), 1);

        // Randomized traffic, including a maximum-length burst
        ready_pct = 70;
        data_pct  = 70;
        cmd_pct   = 50;
        for (int k = 0; k < 40; k++) begin
            add_cmd($urandom_range(0, 15),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
                    $urandom_range(0, 63), ($urandom_range(0, 4) == 0), 1'b0);
            if (k == 20) add_cmd(15, 255, 63, 1'b0, 1'b0);
        end
        add_cmd(12, 255, 33, 1'b1, 1'b0);
        wait_drain(40000);

        // Reset in the middle of a burst
        ready_pct = 100;
        data_pct  = 100;
        cmd_pct   = 100;
        add_cmd(5, 20, 1, 1'b0, 1'b0);
        n0 = n_beats;
        i = 0;
        while (n_beats < n0 + 3 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("t1_burst_started", n_beats >= n0 + 3, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        data_q.delete();
        allowed = 0;
        consumed = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("t1_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero_but_ready();
        mon_en = 1'b1;
        n0 = n_beats;
        repeat (5) @(negedge clk);
        check("t1_no_more_beats", n_beats, n0);

        // Normal operation resumes after reset
        add_cmd(7, 2, 9, 1'b0, 1'b0);
        wait_drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic check_all_zero_but_ready();
        check("t1_after_r_valid", r_valid, 0);
        check("t1_after_cmd_ready", cmd_ready, 1);
        check("t1_after_busy", busy, 0);
    endtask

endmodule
